// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder.
//   - Store-type encodings for req_store_type (ST_*).
//   - Load-type encodings for req_load_type (LD_*).
//   - FSM state encoding (S_IDLE / S_WAIT / S_RESP).
package dmem_pkg;

    localparam logic [1:0] ST_SB = 2'd0;
    localparam logic [1:0] ST_SH = 2'd1;
    localparam logic [1:0] ST_SW = 2'd2;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LW  = 3'd2;
    localparam logic [2:0] LD_LBU = 3'd4;
    localparam logic [2:0] LD_LHU = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational byte-lane steering for the data-memory responder.
// Ports:
//   addr_lo_i     byte offset within the word (addr[1:0])
//   write_i       1 = store, 0 = load
//   store_type_i  ST_* encoding
//   load_type_i   LD_* encoding
//   wdata_i       right-aligned store data
//   rword_i       word currently held in the array
//   wmask_o       per-byte write enable
//   wword_o       store data replicated onto its lanes
//   ldata_o       extended load data
//   err_o         misaligned access or reserved type
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic        write_i,
    input  logic [1:0]  store_type_i,
    input  logic [2:0]  load_type_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] wword_o,
    output logic [31:0] ldata_o,
    output logic        err_o
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        unique case (addr_lo_i)
            2'd0:    sel_byte = rword_i[7:0];
            2'd1:    sel_byte = rword_i[15:8];
            2'd2:    sel_byte = rword_i[23:16];
            default: sel_byte = rword_i[31:24];
        endcase
        sel_half = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    always_comb begin
        wmask_o = 4'b0000;
        wword_o = wdata_i;
        case (store_type_i)
            ST_SB: begin
                wmask_o = 4'b0001 << addr_lo_i;
                wword_o = {4{wdata_i[7:0]}};
            end
            ST_SH: begin
                wmask_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wword_o = {2{wdata_i[15:0]}};
            end
            ST_SW: wmask_o = 4'b1111;
            default: wmask_o = 4'b0000;
        endcase
    end

    always_comb begin
        ldata_o = 32'h0;
        case (load_type_i)
            LD_LB:  ldata_o = {{24{sel_byte[7]}}, sel_byte};
            LD_LH:  ldata_o = {{16{sel_half[15]}}, sel_half};
            LD_LW:  ldata_o = rword_i;
            LD_LBU: ldata_o = {24'h0, sel_byte};
            LD_LHU: ldata_o = {16'h0, sel_half};
            default: ldata_o = 32'h0;
        endcase
    end

    always_comb begin
        err_o = 1'b0;
        if (write_i) begin
            case (store_type_i)
                ST_SB:   err_o = 1'b0;
                ST_SH:   err_o = addr_lo_i[0];
                ST_SW:   err_o = (addr_lo_i != 2'd0);
                default: err_o = 1'b1;
            endcase
        end else begin
            case (load_type_i)
                LD_LB, LD_LBU: err_o = 1'b0;
                LD_LH, LD_LHU: err_o = addr_lo_i[0];
                LD_LW:         err_o = (addr_lo_i != 2'd0);
                default:       err_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable latency for the core's load/store port.
// One request at a time: IDLE accepts, WAIT burns WAIT_CYCLES, RESP executes the
// access in its first cycle and then presents the response until rsp_ready.
// Ports:
//   clk, reset                    clock and synchronous active-high reset
//   req_valid/req_ready           request handshake
//   req_write, req_addr,
//   req_wdata, req_store_type,
//   req_load_type                 request payload
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata, rsp_err            response payload
//   stat_loads/stores/errors      saturating counters (only with DMEM_STATS_EN)
// Optional build macro: DMEM_STATS_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_store_type,
    input  logic [2:0]  req_load_type,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errors
`endif
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        write_q;
    logic [31:0] addr_q, wdata_q;
    logic [1:0]  st_q;
    logic [2:0]  lt_q;
    logic        accept, mem_we;

    logic [31:0] word_off;
    logic        out_of_range;
    logic [IdxW-1:0] word_idx;
    logic [3:0]  wmask;
    logic [31:0] wword, ldata;
    logic        lane_err, acc_err;

    // Unsigned subtract so addresses below BASE_ADDR wrap high and fail the range test.
    assign word_off     = (addr_q - BASE_ADDR) >> 2;
    assign out_of_range = (word_off >= DEPTH_WORDS);
    assign word_idx     = word_off[IdxW-1:0];
    assign acc_err      = lane_err | out_of_range;

    dmem_lane_unit u_lane (
        .addr_lo_i    (addr_q[1:0]),
        .write_i      (write_q),
        .store_type_i (st_q),
        .load_type_i  (lt_q),
        .wdata_i      (wdata_q),
        .rword_i      (mem[word_idx]),
        .wmask_o      (wmask),
        .wword_o      (wword),
        .ldata_o      (ldata),
        .err_o        (lane_err)
    );

    assign accept = (state_q == S_IDLE) && req_valid;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_RESP;
            end
            S_RESP: begin
                if (!valid_q) begin
                    // Entry cycle: execute the access and latch the response.
                    err_d   = acc_err;
                    rdata_d = (!write_q && !acc_err) ? ldata : 32'h0;
                    mem_we  = write_q && !acc_err;
                    valid_d = 1'b1;
                end else if (rsp_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            st_q    <= req_store_type;
            lt_q    <= req_load_type;
        end
    end

    // Array is never cleared; reset only suppresses a pending write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) mem[word_idx][8*b +: 8] <= wword[8*b +: 8];
            end
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

`ifdef DMEM_STATS_EN
    logic        rsp_hs;
    logic [15:0] loads_q, stores_q, errors_q;

    assign rsp_hs = valid_q && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            loads_q  <= 16'h0;
            stores_q <= 16'h0;
            errors_q <= 16'h0;
        end else if (rsp_hs) begin
            if (err_q) begin
                if (errors_q != 16'hFFFF) errors_q <= errors_q + 16'd1;
            end else if (write_q) begin
                if (stores_q != 16'hFFFF) stores_q <= stores_q + 16'd1;
            end else begin
                if (loads_q != 16'hFFFF) loads_q <= loads_q + 16'd1;
            end
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errors = errors_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_store_type;
    logic [2:0]  req_load_type;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
`ifdef DMEM_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errors;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .WAIT_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_store_type (req_store_type),
        .req_load_type  (req_load_type),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err)
`ifdef DMEM_STATS_EN
        ,
        .stat_loads     (stat_loads),
        .stat_stores    (stat_stores),
        .stat_errors    (stat_errors)
`endif
    );

    // Drive a request, wait for acceptance and the response, then complete the handshake.
    // lat counts clock edges from the accept edge to rsp_valid high (50 = timed out).
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] st, input logic [2:0] lt,
                          output logic [31:0] rd, output logic er, output int lat);
        int n;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        req_store_type = st; req_load_type = lt;
        n = 0;
        while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 4;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, ST_SW, LD_LW, rd, er, lat);
        n_checks += 3;
        if (lat !== 3) begin n_fail++; $display("FAIL sw_latency got %0d want 3", lat); end
        if (er !== 1'b0) begin n_fail++; $display("FAIL sw_err got %b want 0", er); end
        if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata got %h want 0", rd); end
        do_req(1'b0, 32'h10, 32'h0, ST_SW, LD_LW, rd, er, lat);
        n_checks += 3;
        if (lat !== 3) begin n_fail++; $display("FAIL lw_latency got %0d want 3", lat); end
        if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %h want deadbeef", rd); end
        if (er !== 1'b0) begin n_fail++; $display("FAIL lw_err got %b want 0", er); end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h13, 32'h0000_0080, ST_SB, LD_LW, rd, er, lat);
        do_req(1'b0, 32'h13, 32'h0, ST_SW, LD_LB, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_0x13 got %h want ffffff80", rd); end
        do_req(1'b0, 32'h13, 32'h0, ST_SW, LD_LBU, rd, er, lat);
        n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_0x13 got %h want 00000080", rd); end
        do_req(1'b0, 32'h10, 32'h0, ST_SW, LD_LW, rd, er, lat);
        n_checks++; if (rd !== 32'h80ADBEEF) begin n_fail++; $display("FAIL lw_after_sb got %h want 80adbeef", rd); end
        do_req(1'b1, 32'h12, 32'hAAAA_1234, ST_SH, LD_LW, rd, er, lat);
        do_req(1'b0, 32'h12, 32'h0, ST_SW, LD_LHU, rd, er, lat);
        n_checks++; if (rd !== 32'h00001234) begin n_fail++; $display("FAIL lhu_0x12 got %h want 00001234", rd); end
        do_req(1'b0, 32'h10, 32'h0, ST_SW, LD_LH, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFFBEEF) begin n_fail++; $display("FAIL lh_0x10 got %h want ffffbeef", rd); end
        do_req(1'b0, 32'h11, 32'h0, ST_SW, LD_LB, rd, er, lat);
        n_checks++; if (rd !== 32'hFFFFFFBE) begin n_fail++; $display("FAIL lb_0x11 got %h want ffffffbe", rd); end
        do_req(1'b0, 32'h11, 32'h0, ST_SW, LD_LH, rd, er, lat);
        n_checks += 2;
        if (er !== 1'b1) begin n_fail++; $display("FAIL lh_misaligned_err got %b want 1", er); end
        if (rd !== 32'h0) begin n_fail++; $display("FAIL lh_misaligned_rdata got %h want 0", rd); end
        do_req(1'b1, 32'h11, 32'hFFFF_FFFF, ST_SW, LD_LW, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL sw_misaligned_err got %b want 1", er); end
        do_req(1'b0, 32'h10, 32'h0, ST_SW, LD_LW, rd, er, lat);
        n_checks++; if (rd !== 32'h1234BEEF) begin n_fail++; $display("FAIL lw_after_bad_sw got %h want 1234beef", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, 32'h0000_1000, 32'h0, ST_SW, LD_LW, rd, er, lat);
        n_checks += 2;
        if (er !== 1'b1) begin n_fail++; $display("FAIL oor_err got %b want 1", er); end
        if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rdata got %h want 0", rd); end
        do_req(1'b0, 32'hFFFF_FFFC, 32'h0, ST_SW, LD_LW, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oor_high_err got %b want 1", er); end
        do_req(1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, ST_SW, LD_LW, rd, er, lat);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL last_word_sw_err got %b want 0", er); end
        do_req(1'b0, 32'h0000_0FFC, 32'h0, ST_SW, LD_LW, rd, er, lat);
        n_checks++; if (rd !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL last_word_lw got %h want a5a5a5a5", rd); end
        do_req(1'b1, 32'h10, 32'h0, 2'd3, LD_LW, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL st_reserved_err got %b want 1", er); end
        do_req(1'b0, 32'h10, 32'h0, ST_SW, 3'd3, rd, er, lat);
        n_checks += 2;
        if (er !== 1'b1) begin n_fail++; $display("FAIL ld_reserved_err got %b want 1", er); end
        if (rd !== 32'h0) begin n_fail++; $display("FAIL ld_reserved_rdata got %h want 0", rd); end
        do_req(1'b0, 32'h10, 32'h0, ST_SW, LD_LW, rd, er, lat);
        n_checks++; if (rd !== 32'h1234BEEF) begin n_fail++; $display("FAIL lw_after_reserved_st got %h want 1234beef", rd); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_load_type = LD_LW;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL bp_latency got %0d want 3", lat); end
        // A competing store that must be ignored while the response is pending.
        req_valid = 1'b1; req_write = 1'b1; req_wdata = 32'h0; req_store_type = ST_SW;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks += 4;
            if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, rsp_valid); end
            if (rsp_rdata !== 32'h1234BEEF) begin n_fail++; $display("FAIL bp_rdata[%0d] got %h want 1234beef", i, rsp_rdata); end
            if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL bp_err[%0d] got %b want 0", i, rsp_err); end
            if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready[%0d] got %b want 0", i, req_ready); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_checks += 2;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_valid_drop got %b want 0", rsp_valid); end
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_req_ready_back got %b want 1", req_ready); end
        do_req(1'b0, 32'h10, 32'h0, ST_SW, LD_LW, rd, er, lat);
        n_checks++; if (rd !== 32'h1234BEEF) begin n_fail++; $display("FAIL bp_ignored_store got %h want 1234beef", rd); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, 32'h20, 32'h1111_1111, ST_SW, LD_LW, rd, er, lat);
        do_req(1'b0, 32'h10, 32'h0, ST_SW, LD_LW, rd, er, lat);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h2222_2222; req_store_type = ST_SW;
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks += 4;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL abort_req_ready got %b want 1", req_ready); end
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rsp_valid got %b want 0", rsp_valid); end
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL abort_rsp_rdata got %h want 0", rsp_rdata); end
        if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL abort_rsp_err got %b want 0", rsp_err); end
        repeat (4) @(posedge clk);
        #1;
        do_req(1'b0, 32'h20, 32'h0, ST_SW, LD_LW, rd, er, lat);
        n_checks++; if (rd !== 32'h11111111) begin n_fail++; $display("FAIL abort_no_write got %h want 11111111", rd); end
    endtask

`ifdef DMEM_STATS_EN
    task automatic test_stats();
        logic [31:0] rd; logic er; int lat;
        apply_reset();
        n_checks++;
        if (stat_loads !== 16'd0) begin n_fail++; $display("FAIL stats_clear got %0d want 0", stat_loads); end
        do_req(1'b0, 32'h10, 32'h0, ST_SW, LD_LW, rd, er, lat);
        do_req(1'b1, 32'h30, 32'h5, ST_SW, LD_LW, rd, er, lat);
        do_req(1'b0, 32'h11, 32'h0, ST_SW, LD_LW, rd, er, lat);
        do_req(1'b0, 32'h30, 32'h0, ST_SW, LD_LBU, rd, er, lat);
        do_req(1'b1, 32'h34, 32'h6, ST_SB, LD_LW, rd, er, lat);
        do_req(1'b0, 32'h34, 32'h0, ST_SW, LD_LHU, rd, er, lat);
        n_checks += 3;
        if (stat_loads !== 16'd3) begin n_fail++; $display("FAIL stat_loads got %0d want 3", stat_loads); end
        if (stat_stores !== 16'd2) begin n_fail++; $display("FAIL stat_stores got %0d want 2", stat_stores); end
        if (stat_errors !== 16'd1) begin n_fail++; $display("FAIL stat_errors got %0d want 1", stat_errors); end
    endtask
`endif

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_store_type = ST_SW; req_load_type = LD_LW; rsp_ready = 1'b0;
        test_reset();
        test_word();
        test_byte_half();
        test_errors();
        test_backpressure();
        test_reset_abort();
`ifdef DMEM_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
